state_switch_arbiter: RTL

Arbitrates on/off state-change requests from NREQ requesters onto a single shared two-state resource and sequences each change through a settle window. A minimum dwell time is enforced between changes. The block drives the resource's 2-bit state encoding (2'h1 on, 2'h3 off, 2'h0 transitioning) and keeps a switch counter for status readback.

---
 rtl/state_switch_arbiter_if.sv | 30 +++
 rtl/state_switch_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/state_switch_arbiter_if.sv
// Request/grant and status bundle between requesters and the state switch arbiter.
// Requesters hold the master side; the arbiter holds the slave side.
interface state_switch_arbiter_if #(
   parameter int unsigned NREQ = 4
);
   logic [NREQ-1:0] req;
   logic [NREQ-1:0] req_on;
   logic [NREQ-1:0] gnt;
   logic [1:0]      state_out;
   logic            busy;
   logic [7:0]      sw_count;

   modport master (
      output req,
      output req_on,
      input  gnt,
      input  state_out,
      input  busy,
      input  sw_count
   );

   modport slave (
      input  req,
      input  req_on,
      output gnt,
      output state_out,
      output busy,
      output sw_count
   );
endinterface

// File: rtl/state_switch_arbiter.sv
// Round-robin arbiter that sequences on/off changes of a shared resource through a
// settle window, enforces a dwell time between changes and counts completed changes.
module state_switch_arbiter #(
   parameter int unsigned NREQ   = 4,
   parameter int unsigned DWELL  = 8,
   parameter int unsigned SETTLE = 2
) (
   input logic                   clk,
   input logic                   rst,
   state_switch_arbiter_if.slave bus
);
   localparam int unsigned DW = $clog2(DWELL + 1);
   localparam int unsigned SW = $clog2(SETTLE + 1);
   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   // Encodings match the resource state bus so state_q drives state_out directly.
   typedef enum logic [1:0] {
      StSettle = 2'h0,
      StOn     = 2'h1,
      StOff    = 2'h3
   } state_e;

   state_e          state_q, state_d;
   logic            target_q, target_d;
   logic [SW-1:0]   settle_q, settle_d;
   logic [DW-1:0]   dwell_q, dwell_d;
   logic [PW-1:0]   rr_q, rr_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [7:0]      sw_q, sw_d;
   logic            busy_q, busy_d;

   logic            cur_on;
   logic            arb_en;
   logic            win_found;
   logic [PW-1:0]   win_idx;
   logic [PW-1:0]   idx_pw;
   int unsigned     idx;

   assign cur_on = (state_q == StOn);
   // A grant already in flight blocks arbitration so a requester dropping req is not re-granted.
   assign arb_en = (state_q != StSettle) && (dwell_q == '0) && (gnt_q == '0) && (|bus.req);

   // Round-robin search starting at the pointer, wrapping at NREQ.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      idx       = 0;
      idx_pw    = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         idx = 32'(rr_q) + i;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         idx_pw = PW'(idx);
         if (!win_found && bus.req[idx_pw]) begin
            win_found = 1'b1;
            win_idx   = idx_pw;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      settle_d = settle_q;
      dwell_d  = dwell_q;
      rr_d     = rr_q;
      gnt_d    = '0;
      sw_d     = sw_q;

      unique case (state_q)
         StOn, StOff: begin
            if (dwell_q != '0) begin
               dwell_d = dwell_q - 1'b1;
            end
            if (arb_en && win_found) begin
               gnt_d[win_idx] = 1'b1;
               rr_d = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
               if (bus.req_on[win_idx] != cur_on) begin
                  state_d  = StSettle;
                  target_d = bus.req_on[win_idx];
                  settle_d = SW'(SETTLE - 1);
               end
            end
         end
         StSettle: begin
            if (settle_q == '0) begin
               state_d = target_q ? StOn : StOff;
               dwell_d = DW'(DWELL);
               sw_d    = sw_q + 8'd1;
            end else begin
               settle_d = settle_q - 1'b1;
            end
         end
         default: begin
            state_d = StOff;
         end
      endcase

      busy_d = (state_d == StSettle) || (dwell_d != '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StOff;
         target_q <= 1'b0;
         settle_q <= '0;
         dwell_q  <= '0;
         rr_q     <= '0;
         gnt_q    <= '0;
         sw_q     <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         settle_q <= settle_d;
         dwell_q  <= dwell_d;
         rr_q     <= rr_d;
         gnt_q    <= gnt_d;
         sw_q     <= sw_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.state_out = state_q;
   assign bus.busy      = busy_q;
   assign bus.sw_count  = sw_q;

endmodule
